// File: rtl/mem_io_bridge.sv
// Data-port bridge for the single-cycle core: decodes RAM vs. memory-mapped IO
// (LED, synchronised switches, down-counting timer) with same-cycle read data.
module mem_io_bridge #(
  parameter int          RAM_AW  = 10,
  parameter logic [31:0] IO_BASE = 32'h0000_1000,
  parameter int          N_LED   = 10,
  parameter int          N_SW    = 10,
  parameter int          TMR_W   = 32
) (
  input  logic              CLOCK,
  input  logic              RST,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  input  logic              ena_wr,
  input  logic              ena_rd,
  output logic [31:0]       rdata,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  output logic              ram_we,
  output logic              ram_re,
  input  logic [31:0]       ram_rdata,
  input  logic [N_SW-1:0]   sw,
  output logic [N_LED-1:0]  ledr,
  output logic              tmr_irq,
  output logic              bus_err
);

  typedef enum logic [2:0] {
    R_LED    = 3'd0,
    R_SW     = 3'd1,
    R_TCTRL  = 3'd2,
    R_TLOAD  = 3'd3,
    R_TCOUNT = 3'd4
  } io_reg_e;

  typedef struct packed {
    logic done;
    logic auto_rl;
    logic en;
  } tctrl_t;

  // ---------------------------------------------------------------- decode
  logic [31:0] addr_w;
  logic [31:0] io_off;
  logic [2:0]  io_idx;
  logic        ram_hit, io_hit, unmapped;
  logic        unused_addr_lsb;

  assign addr_w          = {addr[31:2], 2'b00};
  assign unused_addr_lsb = ^addr[1:0];
  assign io_off          = addr_w - IO_BASE;
  assign io_idx          = io_off[4:2];

  assign ram_hit  = (addr[31:RAM_AW+2] == '0);
  // RAM wins if a parameterisation ever makes the two regions overlap
  assign io_hit   = !ram_hit && (addr_w >= IO_BASE) && (io_off < 32'h14);
  assign unmapped = !ram_hit && !io_hit;

  assign ram_addr  = addr[RAM_AW+1:2];
  assign ram_wdata = wdata;
  assign ram_we    = ena_wr & ram_hit;
  assign ram_re    = ena_rd & ram_hit;

  logic io_we;
  logic led_wr, tctrl_wr, tload_wr;

  assign io_we    = ena_wr & io_hit;
  assign led_wr   = io_we && (io_idx == R_LED);
  assign tctrl_wr = io_we && (io_idx == R_TCTRL);
  assign tload_wr = io_we && (io_idx == R_TLOAD);

  // ---------------------------------------------------------------- state
  logic [1:0][N_SW-1:0] sw_sync;
  tctrl_t               tctrl;
  logic [TMR_W-1:0]     tload;
  logic [TMR_W-1:0]     tcount;
  logic                 expire;

  assign expire = tctrl.en && (tcount == '0);

  always_ff @(posedge CLOCK or posedge RST) begin
    if (RST) begin
      sw_sync <= '0;
    end else begin
      sw_sync[0] <= sw;
      sw_sync[1] <= sw_sync[0];
    end
  end

  always_ff @(posedge CLOCK or posedge RST) begin
    if (RST) begin
      ledr <= '0;
    end else if (led_wr) begin
      ledr <= wdata[N_LED-1:0];
    end
  end

  always_ff @(posedge CLOCK or posedge RST) begin
    if (RST) begin
      tload <= '0;
    end else if (tload_wr) begin
      tload <= TMR_W'(wdata);
    end
  end

  // A TCTRL write overrides the running count; expiry still raises DONE on
  // that same edge so a W1C racing an expiry never loses the event.
  always_ff @(posedge CLOCK or posedge RST) begin
    if (RST) begin
      tctrl  <= '0;
      tcount <= '0;
    end else begin
      if (tctrl_wr) begin
        tctrl.en      <= wdata[0];
        tctrl.auto_rl <= wdata[1];
        if (wdata[0]) tcount <= tload;
      end else if (tctrl.en) begin
        if (tcount != '0) begin
          tcount <= tcount - 1'b1;
        end else if (tctrl.auto_rl) begin
          tcount <= tload;
        end else begin
          tctrl.en <= 1'b0;
        end
      end

      if (expire) begin
        tctrl.done <= 1'b1;
      end else if (tctrl_wr && wdata[2]) begin
        tctrl.done <= 1'b0;
      end
    end
  end

  assign tmr_irq = tctrl.done;

  always_ff @(posedge CLOCK or posedge RST) begin
    if (RST) begin
      bus_err <= 1'b0;
    end else if ((ena_wr | ena_rd) && unmapped) begin
      bus_err <= 1'b1;
    end
  end

  // ---------------------------------------------------------------- read mux
  logic [31:0] io_rdata;

  always_comb begin
    io_rdata = '0;
    case (io_idx)
      R_LED:    io_rdata = 32'(ledr);
      R_SW:     io_rdata = 32'(sw_sync[1]);
      R_TCTRL:  io_rdata = {29'd0, tctrl.done, tctrl.auto_rl, tctrl.en};
      R_TLOAD:  io_rdata = 32'(tload);
      R_TCOUNT: io_rdata = 32'(tcount);
      default:  io_rdata = '0;
    endcase
  end

  always_comb begin
    rdata = '0;
    if (ena_rd) begin
      if (ram_hit)     rdata = ram_rdata;
      else if (io_hit) rdata = io_rdata;
    end
  end

endmodule

// File: tb/tb_mem_io_bridge.sv
// Directed bench for mem_io_bridge: decode, LED/SW registers, timer, bus error, reset.
module tb_mem_io_bridge;

  localparam logic [31:0] A_LED    = 32'h1000;
  localparam logic [31:0] A_SW     = 32'h1004;
  localparam logic [31:0] A_TCTRL  = 32'h1008;
  localparam logic [31:0] A_TLOAD  = 32'h100C;
  localparam logic [31:0] A_TCOUNT = 32'h1010;

  logic        CLOCK, RST;
  logic [31:0] addr, wdata, rdata, ram_wdata, ram_rdata;
  logic        ena_wr, ena_rd, ram_we, ram_re, tmr_irq, bus_err;
  logic [9:0]  ram_addr, sw, ledr;

  int errs   = 0;
  int checks = 0;

  mem_io_bridge dut (
    .CLOCK(CLOCK), .RST(RST), .addr(addr), .wdata(wdata), .ena_wr(ena_wr),
    .ena_rd(ena_rd), .rdata(rdata), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_we(ram_we), .ram_re(ram_re), .ram_rdata(ram_rdata), .sw(sw),
    .ledr(ledr), .tmr_irq(tmr_irq), .bus_err(bus_err)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  task automatic cyc();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr = a; wdata = d; ena_wr = 1'b1; ena_rd = 1'b0;
    cyc();
    ena_wr = 1'b0;
  endtask

  task automatic rd_set(input logic [31:0] a);
    addr = a; ena_rd = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b1; addr = '0; wdata = '0; ena_wr = 0; ena_rd = 0;
    ram_rdata = 32'hCAFE_F00D; sw = '0;
    repeat (2) @(posedge CLOCK);
    #1;
    checks++; if (ledr !== 10'd0) begin errs++; $display("FAIL reset_ledr got %h exp 0", ledr); end
    checks++; if (tmr_irq !== 1'b0) begin errs++; $display("FAIL reset_irq got %b exp 0", tmr_irq); end
    checks++; if (bus_err !== 1'b0) begin errs++; $display("FAIL reset_buserr got %b exp 0", bus_err); end
    checks++; if (rdata !== 32'd0) begin errs++; $display("FAIL reset_rdata got %h exp 0", rdata); end
    RST = 1'b0;
  endtask

  task automatic test_led();
    addr = A_LED; wdata = 32'h3FF; ena_wr = 1'b1; ena_rd = 1'b0;
    #1;
    checks++; if (ram_we !== 1'b0) begin errs++; $display("FAIL led_ram_we got %b exp 0", ram_we); end
    cyc();
    ena_wr = 1'b0;
    checks++; if (ledr !== 10'h3FF) begin errs++; $display("FAIL led_value got %h exp 3ff", ledr); end
    rd_set(A_LED);
    checks++; if (rdata !== 32'h0000_03FF) begin errs++; $display("FAIL led_read got %h exp 000003ff", rdata); end
    checks++; if (ram_re !== 1'b0) begin errs++; $display("FAIL led_ram_re got %b exp 0", ram_re); end
    rd_set(32'h1003 - 32'h2);  // 0x1001: byte offset ignored
    checks++; if (rdata !== 32'h0000_03FF) begin errs++; $display("FAIL led_unaligned got %h exp 000003ff", rdata); end
    ena_rd = 1'b0;
  endtask

  task automatic test_ram();
    addr = 32'h10; wdata = 32'hDEAD_BEEF; ena_wr = 1'b1; ena_rd = 1'b0;
    #1;
    checks++; if (ram_we !== 1'b1) begin errs++; $display("FAIL ram_we got %b exp 1", ram_we); end
    checks++; if (ram_addr !== 10'd4) begin errs++; $display("FAIL ram_addr got %h exp 4", ram_addr); end
    checks++; if (ram_wdata !== 32'hDEAD_BEEF) begin errs++; $display("FAIL ram_wdata got %h exp deadbeef", ram_wdata); end
    cyc();
    ena_wr = 1'b0;
    #1;
    checks++; if (ram_we !== 1'b0) begin errs++; $display("FAIL ram_we_drop got %b exp 0", ram_we); end
    ram_rdata = 32'hDEAD_BEEF;
    rd_set(32'h10);
    checks++; if (rdata !== 32'hDEAD_BEEF) begin errs++; $display("FAIL ram_read got %h exp deadbeef", rdata); end
    checks++; if (ram_re !== 1'b1) begin errs++; $display("FAIL ram_re got %b exp 1", ram_re); end
    rd_set(32'hFFC);  // last RAM word
    checks++; if (ram_re !== 1'b1 || ram_addr !== 10'h3FF) begin errs++; $display("FAIL ram_top got re=%b addr=%h exp re=1 addr=3ff", ram_re, ram_addr); end
    rd_set(32'h1000);  // first byte past RAM
    checks++; if (ram_re !== 1'b0) begin errs++; $display("FAIL ram_edge got %b exp 0", ram_re); end
    ena_rd = 1'b0;
  endtask

  task automatic test_sw();
    sw = 10'h155;
    rd_set(A_SW);
    checks++; if (rdata !== 32'd0) begin errs++; $display("FAIL sw_0edge got %h exp 0", rdata); end
    cyc();
    checks++; if (rdata !== 32'd0) begin errs++; $display("FAIL sw_1edge got %h exp 0", rdata); end
    cyc();
    checks++; if (rdata !== 32'h155) begin errs++; $display("FAIL sw_2edge got %h exp 155", rdata); end
    ena_rd = 1'b0;
  endtask

  task automatic test_oneshot();
    wr(A_TLOAD, 32'd5);
    wr(A_TCTRL, 32'h1);
    rd_set(A_TCOUNT);
    checks++; if (rdata !== 32'd5) begin errs++; $display("FAIL os_load got %0d exp 5", rdata); end
    for (int k = 1; k <= 5; k++) begin
      cyc();
      checks++; if (rdata !== 32'(5 - k) || tmr_irq !== 1'b0) begin
        errs++; $display("FAIL os_count%0d got cnt=%0d irq=%b exp cnt=%0d irq=0", k, rdata, tmr_irq, 5 - k);
      end
    end
    cyc();
    checks++; if (tmr_irq !== 1'b1 || rdata !== 32'd0) begin errs++; $display("FAIL os_expire got irq=%b cnt=%0d exp irq=1 cnt=0", tmr_irq, rdata); end
    cyc();
    checks++; if (rdata !== 32'd0) begin errs++; $display("FAIL os_hold got %0d exp 0", rdata); end
    rd_set(A_TCTRL);
    checks++; if (rdata !== 32'h4) begin errs++; $display("FAIL os_tctrl got %h exp 4", rdata); end
    wr(A_TCTRL, 32'h4);
    checks++; if (tmr_irq !== 1'b0) begin errs++; $display("FAIL os_w1c got %b exp 0", tmr_irq); end
  endtask

  task automatic test_auto();
    logic [31:0] exp_c [4] = '{32'd1, 32'd0, 32'd2, 32'd1};
    logic        exp_i [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    wr(A_TLOAD, 32'd2);
    wr(A_TCTRL, 32'h3);
    rd_set(A_TCOUNT);
    checks++; if (rdata !== 32'd2) begin errs++; $display("FAIL au_load got %0d exp 2", rdata); end
    for (int k = 0; k < 4; k++) begin
      cyc();
      checks++; if (rdata !== exp_c[k] || tmr_irq !== exp_i[k]) begin
        errs++; $display("FAIL au_run%0d got cnt=%0d irq=%b exp cnt=%0d irq=%b", k, rdata, tmr_irq, exp_c[k], exp_i[k]);
      end
    end
    wr(A_TCTRL, 32'h7);  // count is 1: not an expiry edge
    checks++; if (tmr_irq !== 1'b0) begin errs++; $display("FAIL au_w1c got %b exp 0", tmr_irq); end
    rd_set(A_TCOUNT);
    checks++; if (rdata !== 32'd2) begin errs++; $display("FAIL au_reload got %0d exp 2", rdata); end
    repeat (3) cyc();
    checks++; if (tmr_irq !== 1'b1 || rdata !== 32'd2) begin errs++; $display("FAIL au_period got irq=%b cnt=%0d exp irq=1 cnt=2", tmr_irq, rdata); end
    repeat (2) cyc();
    checks++; if (rdata !== 32'd0) begin errs++; $display("FAIL au_pre_exp got %0d exp 0", rdata); end
    wr(A_TCTRL, 32'h7);  // count is 0: expiry edge, set wins
    checks++; if (tmr_irq !== 1'b1) begin errs++; $display("FAIL au_w1c_race got %b exp 1", tmr_irq); end
    wr(A_TLOAD, 32'd7);
    rd_set(A_TCOUNT);
    checks++; if (rdata !== 32'd1) begin errs++; $display("FAIL au_tload_live got %0d exp 1", rdata); end
    repeat (2) cyc();
    checks++; if (rdata !== 32'd7) begin errs++; $display("FAIL au_new_reload got %0d exp 7", rdata); end
    wr(A_TCTRL, 32'h0);
    rd_set(A_TCOUNT);
    repeat (2) cyc();
    checks++; if (rdata !== 32'd7) begin errs++; $display("FAIL au_stop_hold got %0d exp 7", rdata); end
    rd_set(A_TCTRL);
    checks++; if (rdata !== 32'h4) begin errs++; $display("FAIL au_stop_tctrl got %h exp 4", rdata); end
    ena_rd = 1'b0;
  endtask

  task automatic test_err();
    ram_rdata = 32'h1234_5678;
    rd_set(32'h1014);
    checks++; if (rdata !== 32'd0) begin errs++; $display("FAIL err_io_edge got %h exp 0", rdata); end
    rd_set(32'h2000);
    checks++; if (rdata !== 32'd0 || bus_err !== 1'b0) begin errs++; $display("FAIL err_pre got rdata=%h err=%b exp 0/0", rdata, bus_err); end
    cyc();
    ena_rd = 1'b0;
    checks++; if (bus_err !== 1'b1) begin errs++; $display("FAIL err_set got %b exp 1", bus_err); end
    repeat (3) cyc();
    checks++; if (bus_err !== 1'b1) begin errs++; $display("FAIL err_sticky got %b exp 1", bus_err); end
  endtask

  task automatic test_reset_mid();
    wr(A_LED, 32'h2A5);
    wr(A_TLOAD, 32'd100);
    wr(A_TCTRL, 32'h1);
    rd_set(A_TCOUNT);
    repeat (3) cyc();
    checks++; if (rdata !== 32'd97 || ledr !== 10'h2A5) begin errs++; $display("FAIL rm_pre got cnt=%0d led=%h exp 97/2a5", rdata, ledr); end
    #1 RST = 1'b1;
    #1;
    checks++; if (rdata !== 32'd0) begin errs++; $display("FAIL rm_tcount got %0d exp 0", rdata); end
    checks++; if (ledr !== 10'd0 || bus_err !== 1'b0 || tmr_irq !== 1'b0) begin
      errs++; $display("FAIL rm_regs got led=%h err=%b irq=%b exp 0/0/0", ledr, bus_err, tmr_irq);
    end
    rd_set(A_SW);
    checks++; if (rdata !== 32'd0) begin errs++; $display("FAIL rm_sw got %h exp 0", rdata); end
    #2 RST = 1'b0;
    rd_set(A_TCOUNT);
    repeat (2) cyc();
    checks++; if (rdata !== 32'd0) begin errs++; $display("FAIL rm_idle got %0d exp 0", rdata); end
    ena_rd = 1'b0;
  endtask

  initial begin
    test_reset();
    test_led();
    test_ram();
    test_sw();
    test_oneshot();
    test_auto();
    test_err();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/mem_io_bridge.md
Name: mem_io_bridge

Overview:
- Sits directly downstream of the single-cycle core's data port.
- Consumes the core's data address (ALU result), write data, and write/read enables.
- Decodes each access to the data RAM or to a small memory-mapped peripheral set: LED register, synchronised switch input, and a down-counting timer with done flag.
- Returns read data combinationally in the same cycle, because the core has no stall.

Parameters:
- RAM_AW, 10, RAM word-address width; RAM occupies byte addresses 0 .. 4*2^RAM_AW-1.
- IO_BASE, 32'h0000_1000, byte base address of the peripheral block.
- N_LED, 10, width of the LED output register.
- N_SW, 10, width of the switch input.
- TMR_W, 32, timer counter width.

Ports:
- CLOCK input 1 system clock, all state on rising edge
- RST input 1 asynchronous active-high reset
- addr input 32 data byte address from core
- wdata input 32 store data from core
- ena_wr input 1 store strobe from core
- ena_rd input 1 load strobe from core
- rdata output 32 load data to core write-back mux
- ram_addr output RAM_AW word address to data RAM (addr[RAM_AW+1:2])
- ram_wdata output 32 pass-through of wdata
- ram_we output 1 RAM write enable
- ram_re output 1 RAM read enable
- ram_rdata input 32 RAM read data, combinational
- sw input N_SW asynchronous board switches
- ledr output N_LED LED register
- tmr_irq output 1 timer done flag level
- bus_err output 1 sticky flag: access to an unmapped address

Behaviour:
- Decoding:
  - Word accesses only; addr[1:0] is ignored.
  - RAM region: addr < 4*2^RAM_AW.
  - IO region: IO_BASE .. IO_BASE+0x13.
  - Anything else is unmapped.
- RAM outputs:
  - ram_we = ena_wr & RAM hit.
  - ram_re = ena_rd & RAM hit.
- IO register map, byte offsets from IO_BASE:
  - 0x00 LED (RW, low N_LED bits).
  - 0x04 SW (RO, zero-extended).
  - 0x08 TCTRL: bit0 EN, bit1 AUTO, bit2 DONE (write-1-to-clear).
  - 0x0C TLOAD (RW).
  - 0x10 TCOUNT (RO).
  - Writes to RO offsets are ignored.
- rdata:
  - Combinational mux: ram_rdata on RAM hit, register value on IO hit, 0 when unmapped or ena_rd=0.
- Switch input:
  - sw passes through a 2-flop synchroniser.
  - An SW read returns the second flop; latency is 2 edges from a sw change.
- Timer:
  - A write to TCTRL with EN=1 loads TCOUNT <= TLOAD on the same edge and sets EN. AUTO is written as given.
  - While EN=1 and TCOUNT!=0: TCOUNT decrements by 1 per cycle.
  - When EN=1 and TCOUNT==0, on that edge:
    - DONE <= 1.
    - If AUTO: TCOUNT <= TLOAD and EN stays 1.
    - Else: EN <= 0 and TCOUNT holds 0.
  - TLOAD=0 with EN=1: DONE is set on the edge following enable, then every cycle while AUTO=1.
  - A TLOAD write while counting changes only TLOAD; it takes effect at the next reload or enable.
  - A TCTRL write with EN=0 stops the count; TCOUNT holds its value.
  - DONE W1C on the same edge as expiry: the set wins, so DONE stays 1.
  - tmr_irq = DONE.
- bus_err:
  - Set on any edge where (ena_wr|ena_rd) and the address is unmapped.
  - Cleared only by reset.
- ena_wr and ena_rd both high: the write takes effect and rdata is still driven. The core never issues this; it is defined only for completeness.
- Reset (RST=1, asynchronous, any time including mid-count):
  - ledr=0, TCTRL=0, TLOAD=0, TCOUNT=0, synchroniser=0, bus_err=0, tmr_irq=0.
  - rdata is combinational, so it equals ram_rdata or 0 according to the inputs.
  - No access is lost beyond the current cycle.

Test Plan:
- LED write: store 0x3FF to 0x1000, then load 0x1000 → ledr=0x3FF, rdata=0x000003FF. ram_we stays 0 throughout.
- RAM pass-through: store 0xDEADBEEF to 0x0000_0010 → ram_we=1 and ram_addr=4 for one cycle. Load the same address with ram_rdata=0xDEADBEEF → rdata=0xDEADBEEF.
- Switch synchroniser: sw 0→0x155 → an SW read returns 0 after 1 edge and 0x155 after 2 edges.
- One-shot timer: TLOAD=5, TCTRL=0x1 → TCOUNT reads 5,4,3,2,1,0. DONE/tmr_irq rises on the 6th edge after enable. EN reads 0 and TCOUNT holds 0.
- Auto-reload and W1C: TLOAD=2, TCTRL=0x3 → DONE pulses set every 3 cycles. A TCTRL write of 0x7 clears DONE on a non-expiry edge; on an expiry edge DONE stays 1.
- Error and reset: load from 0x2000 → rdata=0 and bus_err=1, which persists. Assert RST mid-count → TCOUNT=0, ledr=0, bus_err=0 immediately, without waiting for a clock edge.
